// File: rtl/mult_pkg.sv
// Shared state encoding and width constants for the sequential multiplier.
package mult_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int PROD_WIDTH     = 2 * DATA_WIDTH_DEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mult_seq_adder.sv
// Plain ripple adder shared by the multiplier's shift-and-add iterations.
module mult_seq_adder #(
    parameter int INPUT_DATA  = 33,
    parameter int OUTPUT_DATA = 33
) (
    input  logic [INPUT_DATA-1:0]  a_i,
    input  logic [INPUT_DATA-1:0]  b_i,
    output logic [OUTPUT_DATA-1:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule

// File: rtl/mult_seq.sv
// Iterative 32x32->64 MULT/MULTU sequencer built around one shared adder.
// Optional MULT_EARLY_TERM_EN collapses the trailing zero-multiplier iterations.
//
//   state   | meaning
//   --------+-------------------------------------------------
//   IDLE    | waiting for START
//   CALC    | one shift-and-add step per cycle
//   FIX     | apply sign, load HI/LO
//   DONE    | result valid for one cycle, START accepted again
module mult_seq
    import mult_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  START,
    input  logic                  SIGNED,
    input  logic [DATA_WIDTH-1:0] OP_A,
    input  logic [DATA_WIDTH-1:0] OP_B,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [DATA_WIDTH-1:0] HI,
    output logic [DATA_WIDTH-1:0] LO
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam logic [DATA_WIDTH-1:0] ONE_W    = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]         ONE_P    = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]  CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
    logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0] hi_q, hi_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;
    logic                  neg_q, neg_d;

    logic [DATA_WIDTH-1:0] a_abs, b_abs;
    logic [DATA_WIDTH:0]   add_a, add_b, sum;
    logic [PW-1:0]         prod;

    // Magnitudes: 0x80000000 negates to itself, which is correct read as unsigned.
    assign a_abs = (SIGNED && OP_A[DATA_WIDTH-1]) ? (~OP_A + ONE_W) : OP_A;
    assign b_abs = (SIGNED && OP_B[DATA_WIDTH-1]) ? (~OP_B + ONE_W) : OP_B;

    assign add_a = {1'b0, acc_q};
    assign add_b = mplier_q[0] ? {1'b0, mcand_q} : '0;

    mult_seq_adder #(
        .INPUT_DATA  (DATA_WIDTH + 1),
        .OUTPUT_DATA (DATA_WIDTH + 1)
    ) u_adder (
        .a_i   (add_a),
        .b_i   (add_b),
        .sum_o (sum)
    );

    assign prod = neg_q ? (~{acc_q, mplier_q} + ONE_P) : {acc_q, mplier_q};

`ifdef MULT_EARLY_TERM_EN
    localparam logic [CNT_WIDTH:0] W_EXT = (CNT_WIDTH + 1)'(DATA_WIDTH);

    logic [CNT_WIDTH:0] shamt;
    logic               rest_zero;

    // Only the low DATA_WIDTH-cnt bits of mplier are still unconsumed multiplier bits.
    assign shamt     = W_EXT - {1'b0, cnt_q};
    assign rest_zero = ((mplier_q & ({DATA_WIDTH{1'b1}} >> cnt_q)) == '0);
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        mcand_d  = mcand_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    mcand_d  = a_abs;
                    mplier_d = b_abs;
                    neg_d    = SIGNED & (OP_A[DATA_WIDTH-1] ^ OP_B[DATA_WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = ST_CALC;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_CALC: begin
                {acc_d, mplier_d} = {sum, mplier_q[DATA_WIDTH-1:1]};
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FIX;
                end
`ifdef MULT_EARLY_TERM_EN
                if (rest_zero) begin
                    {acc_d, mplier_d} = {acc_q, mplier_q} >> shamt;
                    state_d = ST_FIX;
                end
`endif
            end
            ST_FIX: begin
                hi_d    = prod[PW-1:DATA_WIDTH];
                lo_d    = prod[DATA_WIDTH-1:0];
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            mcand_q  <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            mcand_q  <= mcand_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign BUSY = (state_q == ST_CALC) || (state_q == ST_FIX);
    assign DONE = (state_q == ST_DONE);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mult_seq.sv
// Scoreboard bench for mult_seq: driver queues expected results, monitor checks on DONE.
`timescale 1ns/1ps
module tb_mult_seq;

    logic        CLK;
    logic        RST_N;
    logic        START;
    logic        SIGNED;
    logic [31:0] OP_A;
    logic [31:0] OP_B;
    logic        BUSY;
    logic        DONE;
    logic [31:0] HI;
    logic [31:0] LO;

    mult_seq dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .START  (START),
        .SIGNED (SIGNED),
        .OP_A   (OP_A),
        .OP_B   (OP_B),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .HI     (HI),
        .LO     (LO)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
        string       name;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sbv;
        if (sgn) begin
            sa  = {{32{a[31]}}, a};
            sbv = {{32{b[31]}}, b};
            return sa * sbv;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    // Cycles from the accept edge to the DONE cycle, counting the DONE cycle.
    function automatic int lat_of(input logic sgn, input logic [31:0] b);
        logic [31:0] m;
        int          p;
        m = (sgn && b[31]) ? (~b + 32'd1) : b;
        p = -1;
        for (int i = 0; i < 32; i++) if (m[i]) p = i;
`ifdef MULT_EARLY_TERM_EN
        if (p < 0) return 3;
        if (p == 31) return 34;
        return p + 4;
`else
        return (p >= -1) ? 34 : 0;
`endif
    endfunction

    // Caller is positioned at a negedge; returns #1 after the accept edge.
    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input bit push, input string name);
        exp_t e;
        START  = 1'b1;
        SIGNED = sgn;
        OP_A   = a;
        OP_B   = b;
        @(posedge CLK);
        #1;
        START = 1'b0;
        if (push) begin
            e.hi   = exp[63:32];
            e.lo   = exp[31:0];
            e.lat  = lat_of(sgn, b);
            e.acc  = cyc;
            e.name = name;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(input string name, output int busy_n);
        busy_n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (BUSY) busy_n++;
            if (DONE) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL %s_timeout: no DONE within 200 cycles", name);
    endtask

    always @(negedge CLK) begin
        if (RST_N && DONE) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: DONE with nothing pending, HI=%h LO=%h, expected no DONE", HI, LO);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_hi"}, 64'(HI), 64'(mon_e.hi));
                check({mon_e.name, "_lo"}, 64'(LO), 64'(mon_e.lo));
                check({mon_e.name, "_latency"}, 64'(cyc - mon_e.acc + 1), 64'(mon_e.lat));
                check({mon_e.name, "_busy_in_done"}, 64'(BUSY), 64'd0);
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs[$];
    int   bn;
    int   dn;
    int   n_rand;
    logic        r_sgn;
    logic [31:0] r_a, r_b;

    initial begin
        RST_N  = 1'b0;
        START  = 1'b0;
        SIGNED = 1'b0;
        OP_A   = '0;
        OP_B   = '0;
        repeat (3) @(negedge CLK);
        check("rst_busy_done", 64'({BUSY, DONE}), 64'd0);
        check("rst_hilo", {HI, LO}, 64'd0);
        RST_N = 1'b1;
        @(negedge CLK);

        issue(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b1, "umax");
        wait_done("umax", bn);
        check("umax_busy_cycles", 64'(bn), 64'd33);

        vecs.push_back('{1'b1, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB, "s_m3x7"});
        vecs.push_back('{1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000, "s_min_sq"});
        vecs.push_back('{1'b1, 32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000, "s_max_min"});
        vecs.push_back('{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, "s_m1xm1"});
        vecs.push_back('{1'b0, 32'h80000000, 32'h00000002, 64'h00000001_00000000, "u_carry"});
        vecs.push_back('{1'b0, 32'hDEADBEEF, 32'h00000000, 64'h0, "u_zero"});
        vecs.push_back('{1'b1, 32'hDEADBEEF, 32'h00000000, 64'h0, "s_zero"});
        vecs.push_back('{1'b0, 32'h00000001, 32'h12345678, 64'h00000000_12345678, "u_ident"});
        vecs.push_back('{1'b0, 32'h00000005, 32'h00000003, 64'h0000000F, "u_5x3"});
        foreach (vecs[i]) begin
            @(negedge CLK);
            issue(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].p, 1'b1, vecs[i].name);
            wait_done(vecs[i].name, bn);
        end

        // Back-to-back accept in the DONE cycle, with a stray START during CALC.
        @(negedge CLK);
        issue(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b1, "b2b_first");
        wait_done("b2b_first", bn);
        issue(1'b0, 32'd6, 32'd7, 64'd42, 1'b1, "b2b_6x7");
        repeat (2) @(negedge CLK);
        START  = 1'b1;
        SIGNED = 1'b1;
        OP_A   = 32'd9;
        OP_B   = 32'd9;
        @(negedge CLK);
        START = 1'b0;
        check("b2b_hold_hilo", {HI, LO}, 64'hFFFFFFFE_00000001);
        check("b2b_busy_during_calc", 64'(BUSY), 64'd1);
        wait_done("b2b_6x7", bn);
        @(negedge CLK);
        check("ignored_start_idle", 64'(BUSY), 64'd0);

        // Reset in the middle of CALC abandons the operation.
        issue(1'b0, 32'h12345678, 32'h00000009, 64'h0, 1'b0, "rst_mid");
        repeat (2) @(negedge CLK);
        RST_N = 1'b0;
        #1;
        check("rst_mid_busy_done", 64'({BUSY, DONE}), 64'd0);
        check("rst_mid_hilo", {HI, LO}, 64'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        dn = 0;
        repeat (40) begin
            @(negedge CLK);
            if (DONE) dn++;
        end
        check("rst_mid_no_done", 64'(dn), 64'd0);
        issue(1'b0, 32'd5, 32'd3, 64'd15, 1'b1, "after_rst_5x3");
        wait_done("after_rst_5x3", bn);

`ifdef MULT_EARLY_TERM_EN
        n_rand = 1000;
`else
        n_rand = 40;
`endif
        for (int i = 0; i < n_rand; i++) begin
            r_sgn = 1'($urandom_range(0, 1));
            r_a   = $urandom;
            r_b   = $urandom >> $urandom_range(0, 31);
            if (i % 17 == 0) r_b = '0;
            @(negedge CLK);
            issue(r_sgn, r_a, r_b, model(r_sgn, r_a, r_b), 1'b1, "rand");
            wait_done("rand", bn);
        end

        repeat (5) @(negedge CLK);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
